pong_game_ctrl: RTL

- Game-sequencing controller for the pong datapath. Owns the match state machine: idle, serve delay, live play, point pause and game over.
- Keeps both scores. Gates ball motion, commands ball recentre/serve direction, and reports winner.
- Sits between the ball/collision logic (miss pulses in, run/load controls out) and the score/overlay renderer.
- Frame-paced: all delays count frame ticks, not clocks.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/rise_detect.sv | 31 +++
 rtl/pong_game_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg
// Shared definitions for the pong game-sequencing logic:
//   - state_t   : match state encoding (IDLE..OVER), also driven on the
//                 debug/overlay 'state' output
//   - SIDE_L/R  : player side encoding used by serve_dir and winner
//   - DEF_*     : default match parameters
//   - max_int   : helper for sizing the frame counter
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SCORE_W      = 4;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 90;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect
// One-bit rising-edge detector. 'rise' is high in the cycle where 'd' is
// high and was low in the previous cycle. The history register clears on
// reset, so a level already high when reset releases counts as an edge.
// Ports:
//   clk   in  clock
//   reset in  synchronous, active-high
//   d     in  level input (already synchronized)
//   rise  out one-cycle rising-edge indication
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_prev;

  // Remember last cycle's level so the edge can be formed combinationally;
  // the consumer registers whatever it does with 'rise'.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_prev <= 1'b0;
    end else begin
      d_prev <= d;
    end
  end

  assign rise = d & ~d_prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
// Match sequencer for the pong datapath: idle, serve delay, live play,
// point pause and game over. Keeps both scores, gates ball motion,
// commands ball recentre / serve direction and reports the winner.
// All delays are counted in frame ticks. All outputs are registered.
// Optional build macro: PONG_PAUSE_EN adds a 'pause' input (rising edge
// toggles a pause flag in SERVE/PLAY/POINT) and a 'paused' output.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   frame_tick          one-cycle pulse per frame
//   start               start button level (edge detected here)
//   miss_l / miss_r     ball left the left / right edge (pulses)
//   ball_run            ball integrates velocity while high
//   ball_load           pulse: recentre ball, load velocity from serve_dir
//   serve_dir           0 = toward left player, 1 = toward right
//   score_l / score_r   player scores
//   game_over, winner   match finished, winning side
//   state               current state encoding (debug/overlay)
//   pause / paused      (PONG_PAUSE_EN only) pause button, pause flag
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               ball_run,
  output logic               ball_load,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
`ifdef PONG_PAUSE_EN
  ,
  input  logic               pause,
  output logic               paused
`endif
);

  localparam int CNT_W = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES)) + 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  state_t             state_q;
  logic [CNT_W-1:0]   frame_cnt;
  logic               start_rise;
  logic               halted;
  logic               toggle_ok;
  logic               enter_over;
  logic [SCORE_W-1:0] score_l_inc;
  logic [SCORE_W-1:0] score_r_inc;

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .rise  (start_rise)
  );

`ifdef PONG_PAUSE_EN
  logic pause_rise;
  logic paused_q;

  rise_detect u_pause_rise (
    .clk   (clk),
    .reset (reset),
    .d     (pause),
    .rise  (pause_rise)
  );

  assign toggle_ok = pause_rise &&
                     (state_q == SERVE || state_q == PLAY || state_q == POINT);
  assign halted    = paused_q;
  assign paused    = paused_q;
`else
  assign toggle_ok = 1'b0;
  assign halted    = 1'b0;
`endif

  assign score_l_inc = score_l + 1'b1;
  assign score_r_inc = score_r + 1'b1;

  // A single miss that brings the scorer to WIN_SCORE ends the match.
  // Simultaneous misses are a replay and never end it.
  assign enter_over = (state_q == PLAY) && !halted &&
                      ((miss_r && !miss_l && score_l_inc == WIN_VAL) ||
                       (miss_l && !miss_r && score_r_inc == WIN_VAL));

  assign state = state_q;

  // Match state machine. Every transition clears the frame counter, which
  // is also how a frame tick coinciding with a state entry gets dropped.
  // While paused nothing advances except the pause flag itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frame_cnt <= '0;
      ball_run  <= 1'b0;
      ball_load <= 1'b0;
      serve_dir <= SIDE_L;
      score_l   <= '0;
      score_r   <= '0;
      game_over <= 1'b0;
      winner    <= SIDE_L;
`ifdef PONG_PAUSE_EN
      paused_q  <= 1'b0;
`endif
    end else begin
      ball_load <= 1'b0;

`ifdef PONG_PAUSE_EN
      if (enter_over) begin
        paused_q <= 1'b0;
      end else if (toggle_ok) begin
        paused_q <= ~paused_q;
      end
`endif

      if (halted) begin
        // Leaving pause in PLAY restarts the ball on the next cycle.
        ball_run <= toggle_ok && (state_q == PLAY);
      end else begin
        unique case (state_q)
          IDLE: begin
            ball_run <= 1'b0;
            score_l  <= '0;
            score_r  <= '0;
            if (start_rise) begin
              state_q   <= SERVE;
              frame_cnt <= '0;
              ball_load <= 1'b1;
              serve_dir <= SIDE_L;
            end
          end

          SERVE: begin
            ball_run <= 1'b0;
            if (frame_tick) begin
              if (frame_cnt == SERVE_LAST) begin
                state_q   <= PLAY;
                frame_cnt <= '0;
                ball_run  <= 1'b1;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end

          PLAY: begin
            ball_run <= 1'b1;
            if (miss_l && miss_r) begin
              state_q   <= SERVE;
              frame_cnt <= '0;
              ball_run  <= 1'b0;
              ball_load <= 1'b1;
            end else if (miss_r || miss_l) begin
              frame_cnt <= '0;
              ball_run  <= 1'b0;
              if (miss_r) begin
                score_l   <= score_l_inc;
                serve_dir <= SIDE_L;
                winner    <= enter_over ? SIDE_L : winner;
              end else begin
                score_r   <= score_r_inc;
                serve_dir <= SIDE_R;
                winner    <= enter_over ? SIDE_R : winner;
              end
              if (enter_over) begin
                state_q   <= OVER;
                game_over <= 1'b1;
              end else begin
                state_q <= POINT;
              end
            end
          end

          POINT: begin
            ball_run <= 1'b0;
            if (frame_tick) begin
              if (frame_cnt == POINT_LAST) begin
                state_q   <= SERVE;
                frame_cnt <= '0;
                ball_load <= 1'b1;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end

          OVER: begin
            ball_run <= 1'b0;
            if (start_rise) begin
              state_q   <= SERVE;
              frame_cnt <= '0;
              ball_load <= 1'b1;
              serve_dir <= SIDE_L;
              score_l   <= '0;
              score_r   <= '0;
              game_over <= 1'b0;
            end
          end

          default: begin
            state_q   <= IDLE;
            frame_cnt <= '0;
            ball_run  <= 1'b0;
          end
        endcase
      end

      // Entering pause stops the ball on the next cycle.
      if (toggle_ok && !halted) begin
        ball_run <= 1'b0;
      end
    end
  end

endmodule
